spi_config_master: RTL and testbench

Synchronous SPI initiator that streams a configuration frame of `NUM_BYTES` bytes into the SNN chip's SPI configuration port (SCLK/MOSI/SS/MISO). It runs on the system clock, generates SCLK by integer division, and pulls bytes from an upstream byte-stream source through a valid/ready handshake. It also returns each byte sampled from MISO. It sits on the host/FPGA side of the link and is the counterpart of the chip's SPI receive interface.

---
 rtl/spi_cfg_pkg.sv | 24 ++
 rtl/spi_sclk_gen.sv | 40 ++++
 rtl/spi_config_master.sv | 174 +++++++++++++++++
 tb/tb_spi_config_master.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_cfg_pkg.sv
// Shared types and frame layout for the SPI configuration master.
// Byte offsets locate each field inside the configuration frame.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    HOLD,
    GAP
  } spi_state_t;

  localparam int DEFAULT_NUM_BYTES = 224;

  localparam int OFS_SPIKES     = 0;
  localparam int OFS_DECAY      = 16;
  localparam int OFS_REFRACTORY = 32;
  localparam int OFS_THRESHOLD  = 48;
  localparam int OFS_DIV_VALUE  = 64;
  localparam int OFS_WEIGHTS    = 72;
  localparam int OFS_DELAYS     = 136;
  localparam int OFS_DEBUG_CFG  = 200;

endpackage

// File: rtl/spi_sclk_gen.sv
// SCLK half-period divider with one-cycle edge strobes.
// Held cleared (SCLK low, count zero) whenever not enabled.
module spi_sclk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic system_clock,
  input  logic reset,
  input  logic en,
  output logic rise_en,
  output logic fall_en,
  output logic sclk
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap    = en && (cnt == LAST);
  assign rise_en = wrap && !sclk;
  assign fall_en = wrap && sclk;

  // Divider count and SCLK flop; toggles at the end of each half-period
  always_ff @(posedge system_clock) begin
    if (!reset) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_config_master.sv
// Mode-0 SPI initiator streaming a configuration frame, MSB first.
// Bytes arrive over valid/ready; MISO bytes are returned per byte.
module spi_config_master
  import spi_cfg_pkg::*;
#(
  parameter int NUM_BYTES = DEFAULT_NUM_BYTES,
  parameter int CLK_DIV   = 4
) (
  input  logic       system_clock,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       SCLK,
  output logic       MOSI,
  output logic       SS,
  input  logic       MISO
);

  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [BW-1:0] LAST_BYTE = BW'(NUM_BYTES - 1);
  localparam logic [HW-1:0] LAST_HALF = HW'(CLK_DIV - 1);

  spi_state_t    state;
  spi_state_t    state_n;
  logic [2:0]    bit_cnt;
  logic [BW-1:0] byte_cnt;
  logic [HW-1:0] hcnt;
  logic [6:0]    tx_sh;
  logic [7:0]    rx_sh;
  logic          aborted;
  logic          sclk_en;
  logic          rise_en;
  logic          fall_en;
  logic          hold_end;
  logic          last_bit;
  logic          last_byte;

  assign tx_ready  = (state == LOAD);
  assign sclk_en   = (state == SHIFT) && !abort;
  assign hold_end  = (hcnt == LAST_HALF);
  assign last_bit  = (bit_cnt == 3'd7);
  assign last_byte = (byte_cnt == LAST_BYTE);

  spi_sclk_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_sclk (
    .system_clock(system_clock),
    .reset       (reset),
    .en          (sclk_en),
    .rise_en     (rise_en),
    .fall_en     (fall_en),
    .sclk        (SCLK)
  );

  // State register
  always_ff @(posedge system_clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next-state logic; abort wins over any handshake or bit strobe
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (start) state_n = LOAD;
      LOAD: begin
        if (abort)         state_n = HOLD;
        else if (tx_valid) state_n = SHIFT;
      end
      SHIFT: begin
        if (abort)
          state_n = HOLD;
        else if (fall_en && last_bit)
          state_n = last_byte ? HOLD : LOAD;
      end
      HOLD:  if (hold_end) state_n = GAP;
      GAP:   if (hold_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Half-period timer for HOLD and GAP, restarted on every state change
  always_ff @(posedge system_clock) begin
    if (!reset)
      hcnt <= '0;
    else if (state_n != state)
      hcnt <= '0;
    else if (state == HOLD || state == GAP)
      hcnt <= hcnt + 1'b1;
    else
      hcnt <= '0;
  end

  // Datapath: shift registers, counters and registered outputs
  always_ff @(posedge system_clock) begin
    if (!reset) begin
      SS       <= 1'b1;
      MOSI     <= 1'b0;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_cnt  <= 3'd0;
      byte_cnt <= '0;
      tx_sh    <= 7'h00;
      rx_sh    <= 8'h00;
      aborted  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      done     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            SS       <= 1'b0;
            byte_cnt <= '0;
            aborted  <= 1'b0;
          end
        end
        LOAD: begin
          if (abort) begin
            aborted <= 1'b1;
          end else if (tx_valid) begin
            MOSI    <= tx_byte[7];
            tx_sh   <= tx_byte[6:0];
            bit_cnt <= 3'd0;
            rx_sh   <= 8'h00;
          end
        end
        SHIFT: begin
          if (abort) begin
            aborted <= 1'b1;
            MOSI    <= 1'b0;
          end else begin
            if (rise_en)
              rx_sh <= {rx_sh[6:0], MISO};
            if (fall_en) begin
              if (last_bit) begin
                rx_byte  <= rx_sh;
                rx_valid <= 1'b1;
                if (last_byte) MOSI <= 1'b0;
                else byte_cnt <= byte_cnt + 1'b1;
              end else begin
                MOSI    <= tx_sh[6];
                tx_sh   <= {tx_sh[5:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
        end
        HOLD: begin
          if (abort) aborted <= 1'b1;
          if (hold_end) begin
            SS   <= 1'b1;
            done <= !(aborted || abort);
          end
        end
        GAP: begin
          if (hold_end) busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_config_master.sv
// Directed bench for spi_config_master: loopback slave, stalls,
// abort, mid-frame reset and a full-size frame timing check.
module tb_spi_config_master;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic       done;
  logic       sclk;
  logic       mosi;
  logic       ss;
  logic       miso;

  logic       b_rst_n;
  logic       b_start;
  logic       b_abort;
  logic [7:0] b_tx_byte;
  logic       b_tx_valid;
  logic       b_tx_ready;
  logic [7:0] b_rx_byte;
  logic       b_rx_valid;
  logic       b_busy;
  logic       b_done;
  logic       b_sclk;
  logic       b_mosi;
  logic       b_ss;
  logic       b_miso;

  int checks;
  int failures;

  logic [23:0] chain;
  int          rises;
  int          dones;
  logic [7:0]  rx_q[$];
  int          ss_run;
  int          ss_gap;

  logic [7:0] send_q[3];
  int         ncyc;
  bit         stall_ok;
  bit         tmo;
  int         ss_lat;
  int         ab_rises;
  logic       f_busy;
  logic       f_ss;
  logic       f_rdy;
  int         ss_low;

  assign miso = mosi;

  spi_config_master #(
    .NUM_BYTES(3),
    .CLK_DIV  (2)
  ) u_dut (
    .system_clock(clk),
    .reset       (rst_n),
    .start       (start),
    .abort       (abort),
    .tx_byte     (tx_byte),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_byte     (rx_byte),
    .rx_valid    (rx_valid),
    .busy        (busy),
    .done        (done),
    .SCLK        (sclk),
    .MOSI        (mosi),
    .SS          (ss),
    .MISO        (miso)
  );

  spi_config_master #(
    .NUM_BYTES(224),
    .CLK_DIV  (2)
  ) u_big (
    .system_clock(clk),
    .reset       (b_rst_n),
    .start       (b_start),
    .abort       (b_abort),
    .tx_byte     (b_tx_byte),
    .tx_valid    (b_tx_valid),
    .tx_ready    (b_tx_ready),
    .rx_byte     (b_rx_byte),
    .rx_valid    (b_rx_valid),
    .busy        (b_busy),
    .done        (b_done),
    .SCLK        (b_sclk),
    .MOSI        (b_mosi),
    .SS          (b_ss),
    .MISO        (b_miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: shift chain clocked by SCLK rising edges
  always @(posedge sclk) begin
    chain = {chain[22:0], mosi};
    rises = rises + 1;
  end

  // Output monitor sampled away from the active edge
  always @(negedge clk) begin
    if (rx_valid) rx_q.push_back(rx_byte);
    if (done) dones = dones + 1;
    if (ss === 1'b1) begin
      ss_run = ss_run + 1;
    end else begin
      if (ss_run > 0) ss_gap = ss_run;
      ss_run = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_frame(input int stall_len, input int abort_at,
                           input bit spam);
    int idx;
    int stall;
    int since;
    int ab_n;
    bit hs;
    idx = 0;
    stall = stall_len;
    since = 0;
    ab_n = -1;
    ncyc = 0;
    stall_ok = 1'b1;
    tmo = 1'b1;
    ss_lat = 0;
    ab_rises = -1;
    rises = 0;
    chain = 24'h0;
    dones = 0;
    rx_q.delete();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    f_busy = busy;
    f_ss = ss;
    f_rdy = tx_ready;
    for (int c = 0; c < 2000; c++) begin
      abort = 1'b0;
      start = spam;
      if (ab_n >= 0) begin
        ab_n++;
        if (ss === 1'b1 && ss_lat == 0) ss_lat = ab_n;
      end
      if (busy !== 1'b1) begin
        tmo = 1'b0;
        break;
      end
      ncyc++;
      if (abort_at > 0 && idx == 2 && ab_n < 0) begin
        since++;
        if (since == abort_at) begin
          abort = 1'b1;
          ab_n = 0;
          ab_rises = rises;
        end
      end
      if (tx_ready && idx == 1 && stall > 0) begin
        tx_valid = 1'b0;
        stall--;
        if (ss !== 1'b0 || sclk !== 1'b0) stall_ok = 1'b0;
      end else if (idx < 3) begin
        tx_valid = 1'b1;
        tx_byte = send_q[idx];
      end else begin
        tx_valid = 1'b0;
      end
      hs = tx_valid && tx_ready && !abort;
      @(negedge clk);
      if (hs) idx++;
    end
    start = 1'b0;
    abort = 1'b0;
    tx_valid = 1'b0;
  endtask

  initial begin
    int n;
    int bd;
    checks = 0;
    failures = 0;
    rises = 0;
    dones = 0;
    chain = 24'h0;
    ss_run = 0;
    ss_gap = 0;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    tx_byte = 8'h00;
    tx_valid = 1'b0;
    b_rst_n = 1'b0;
    b_start = 1'b0;
    b_abort = 1'b0;
    b_tx_byte = 8'h5C;
    b_tx_valid = 1'b1;
    b_miso = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_ss", ss, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_tx_ready", tx_ready, 0);
    check("rst_rx_byte", rx_byte, 8'h00);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    b_rst_n = 1'b1;

    rises = 0;
    ss_low = 0;
    repeat (100) begin
      @(negedge clk);
      if (ss !== 1'b1 || busy !== 1'b0) ss_low++;
    end
    check("idle_rises", rises, 0);
    check("idle_ss_busy", ss_low, 0);

    send_q = '{8'h01, 8'h3C, 8'hA5};
    run_frame(0, 0, 1'b0);
    check("f1_timeout", tmo, 0);
    check("f1_busy_n1", f_busy, 1);
    check("f1_ss_n1", f_ss, 0);
    check("f1_ready_n1", f_rdy, 1);
    check("f1_chain", chain, 24'h013CA5);
    check("f1_rx_count", rx_q.size(), 3);
    check("f1_rx_seq", {rx_q[0], rx_q[1], rx_q[2]}, 24'h013CA5);
    check("f1_done", dones, 1);
    check("f1_rises", rises, 24);
    check("f1_cycles", ncyc, 103);

    send_q = '{8'h81, 8'h7E, 8'hC3};
    run_frame(37, 0, 1'b0);
    check("stall_timeout", tmo, 0);
    check("stall_ss_sclk", stall_ok, 1);
    check("stall_chain", chain, 24'h817EC3);
    check("stall_rx_seq", {rx_q[0], rx_q[1], rx_q[2]}, 24'h817EC3);
    check("stall_cycles", ncyc, 140);
    check("stall_done", dones, 1);

    send_q = '{8'h11, 8'h22, 8'h33};
    run_frame(0, 10, 1'b0);
    check("abort_timeout", tmo, 0);
    check("abort_rises", rises, ab_rises);
    check("abort_ss_lat", (ss_lat >= 1 && ss_lat <= 3), 1);
    check("abort_no_done", dones, 0);
    check("abort_rx_count", rx_q.size(), 1);

    send_q = '{8'h5A, 8'hC3, 8'h0F};
    run_frame(0, 0, 1'b0);
    check("clean_chain", chain, 24'h5AC30F);
    check("clean_rises", rises, 24);
    check("clean_done", dones, 1);

    send_q = '{8'hF0, 8'h0F, 8'h96};
    run_frame(0, 0, 1'b1);
    check("spam_cycles", ncyc, 103);
    check("spam_done", dones, 1);
    check("spam_chain", chain, 24'hF00F96);

    send_q = '{8'h24, 8'h42, 8'hE7};
    run_frame(0, 0, 1'b0);
    check("b2b_ss_gap", (ss_gap >= 2), 1);
    check("b2b_chain", chain, 24'h2442E7);

    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    repeat (20) @(negedge clk);
    check("big_busy_mid", b_busy, 1);
    b_rst_n = 1'b0;
    @(negedge clk);
    check("big_rst_ss", b_ss, 1);
    check("big_rst_sclk", b_sclk, 0);
    check("big_rst_busy", b_busy, 0);
    b_rst_n = 1'b1;
    @(negedge clk);
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    n = 0;
    bd = 0;
    for (int c = 0; c < 10000; c++) begin
      if (b_busy !== 1'b1) break;
      n++;
      if (b_done === 1'b1) bd++;
      @(negedge clk);
    end
    check("big_cycles", n, 7396);
    check("big_done", bd, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
